// File: rtl/seg_capture.sv
// seg_capture: rebuilds the hex value and leading-blank count shown on a
// multiplexed 4-digit seven-segment bus, and flags malformed scans.
//
// state  | meaning
// HUNT   | no frame in progress; wait for digit0 with a legal code
// D1     | digit0 captured; expect digit1 select (0010)
// D2     | digit1 captured; expect digit2 select (0100)
// D3     | digit2 captured; expect digit3 select (1000), frame completes
// D0WAIT | frame just completed; expect digit0 of the next frame
module seg_capture #(
    parameter logic [15:0] MAX_HOLD = 16'd65535
) (
    input  logic        IN_clk,
    input  logic        IN_rst,
    input  logic [3:0]  IN_choice,
    input  logic [7:0]  IN_seg,
    output logic [15:0] OUT_value,
    output logic [2:0]  OUT_off_number,
    output logic        OUT_valid,
    output logic        OUT_err
);

    typedef enum logic [2:0] {HUNT, D1, D2, D3, D0WAIT} state_t;

    state_t      state, state_nxt;
    logic [3:0]  prev_choice;
    logic [15:0] hold_cnt;
    logic [11:0] nib_buf;
    logic [2:0]  blank_buf;

    logic        seg_legal, seg_blank;
    logic [3:0]  seg_nib;
    logic [3:0]  exp_choice;
    logic        is_new, is_onehot, hold_at_limit;
    logic        cap_digit, frame_done, err_nxt, hold_clr, hold_inc;
    logic        pat_ok;
    logic [2:0]  frame_off;
    logic [3:0]  blank_all;

    // Active-low segment byte to nibble; blank reads as nibble 0.
    always_comb begin
        seg_legal = 1'b1;
        seg_blank = 1'b0;
        seg_nib   = 4'h0;
        case (IN_seg)
            8'h03: seg_nib = 4'h0;
            8'h9F: seg_nib = 4'h1;
            8'h25: seg_nib = 4'h2;
            8'h0D: seg_nib = 4'h3;
            8'h99: seg_nib = 4'h4;
            8'h49: seg_nib = 4'h5;
            8'h41: seg_nib = 4'h6;
            8'h1F: seg_nib = 4'h7;
            8'h01: seg_nib = 4'h8;
            8'h09: seg_nib = 4'h9;
            8'h11: seg_nib = 4'hA;
            8'hC1: seg_nib = 4'hB;
            8'h63: seg_nib = 4'hC;
            8'h85: seg_nib = 4'hD;
            8'h61: seg_nib = 4'hE;
            8'h71: seg_nib = 4'hF;
            8'hFF: seg_blank = 1'b1;
            default: seg_legal = 1'b0;
        endcase
    end

    // Leading blanks must run contiguously down from digit3.
    always_comb begin
        blank_all = {seg_blank, blank_buf};
        pat_ok    = 1'b1;
        frame_off = 3'd0;
        case (blank_all)
            4'b0000: frame_off = 3'd0;
            4'b1000: frame_off = 3'd1;
            4'b1100: frame_off = 3'd2;
            4'b1110: frame_off = 3'd3;
            4'b1111: frame_off = 3'd4;
            default: pat_ok = 1'b0;
        endcase
    end

    assign is_new        = (IN_choice != prev_choice);
    assign is_onehot     = (IN_choice != 4'b0000) && ((IN_choice & (IN_choice - 4'd1)) == 4'b0000);
    assign hold_at_limit = (({1'b0, hold_cnt} + 17'd1) >= {1'b0, MAX_HOLD});

    // State register.
    always_ff @(posedge IN_clk or posedge IN_rst) begin
        if (IN_rst) state <= HUNT;
        else        state <= state_nxt;
    end

    // Next-state and per-cycle control: capture, frame completion, errors.
    always_comb begin
        state_nxt  = state;
        cap_digit  = 1'b0;
        frame_done = 1'b0;
        err_nxt    = 1'b0;
        hold_clr   = 1'b0;
        hold_inc   = 1'b0;
        case (state)
            D1:      exp_choice = 4'b0010;
            D2:      exp_choice = 4'b0100;
            D3:      exp_choice = 4'b1000;
            default: exp_choice = 4'b0001;
        endcase
        if (state == HUNT) begin
            hold_clr = 1'b1;
            if (IN_choice == 4'b0001 && seg_legal) begin
                cap_digit = 1'b1;
                state_nxt = D1;
            end
        end else if (is_new) begin
            hold_clr = 1'b1;
            if (!is_onehot || IN_choice != exp_choice || !seg_legal) begin
                err_nxt   = 1'b1;
                state_nxt = HUNT;
            end else begin
                cap_digit = 1'b1;
                case (state)
                    D1:      state_nxt = D2;
                    D2:      state_nxt = D3;
                    D3: begin
                        if (pat_ok) begin
                            frame_done = 1'b1;
                            state_nxt  = D0WAIT;
                        end else begin
                            err_nxt   = 1'b1;
                            state_nxt = HUNT;
                        end
                    end
                    default: state_nxt = D1;
                endcase
            end
        end else if (hold_at_limit) begin
            hold_clr  = 1'b1;
            err_nxt   = 1'b1;
            state_nxt = HUNT;
        end else begin
            hold_inc = 1'b1;
        end
    end

    // Digit buffer, hold counter and registered outputs.
    always_ff @(posedge IN_clk or posedge IN_rst) begin
        if (IN_rst) begin
            prev_choice    <= 4'b0000;
            hold_cnt       <= 16'd0;
            nib_buf        <= 12'h000;
            blank_buf      <= 3'b000;
            OUT_value      <= 16'h0000;
            OUT_off_number <= 3'd0;
            OUT_valid      <= 1'b0;
            OUT_err        <= 1'b0;
        end else begin
            prev_choice <= IN_choice;
            OUT_valid   <= frame_done;
            OUT_err     <= err_nxt;
            if (hold_clr)      hold_cnt <= 16'd0;
            else if (hold_inc) hold_cnt <= hold_cnt + 16'd1;
            if (cap_digit) begin
                case (state)
                    D1: begin
                        nib_buf[7:4] <= seg_nib;
                        blank_buf[1] <= seg_blank;
                    end
                    D2: begin
                        nib_buf[11:8] <= seg_nib;
                        blank_buf[2]  <= seg_blank;
                    end
                    D3: ;
                    default: begin
                        nib_buf[3:0] <= seg_nib;
                        blank_buf[0] <= seg_blank;
                    end
                endcase
            end
            if (frame_done) begin
                OUT_value      <= {seg_nib, nib_buf};
                OUT_off_number <= frame_off;
            end
        end
    end

endmodule

// File: tb/tb_seg_capture.sv
// Directed bench for seg_capture: expected frame/error events are queued as
// stimulus is driven and popped when the DUT pulses OUT_valid or OUT_err.
module tb_seg_capture;

    logic        IN_clk = 1'b0;
    logic        IN_rst = 1'b1;
    logic [3:0]  IN_choice = 4'b0000;
    logic [7:0]  IN_seg = 8'hFF;
    logic [15:0] OUT_value;
    logic [2:0]  OUT_off_number;
    logic        OUT_valid;
    logic        OUT_err;

    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic        is_err;
        logic [15:0] value;
        logic [2:0]  off;
    } ev_t;

    ev_t         sb[$];
    ev_t         mon_e;
    logic [15:0] mdl_value = 16'h0000;
    logic [2:0]  mdl_off = 3'd0;

    seg_capture #(.MAX_HOLD(16'd4)) dut (
        .IN_clk(IN_clk),
        .IN_rst(IN_rst),
        .IN_choice(IN_choice),
        .IN_seg(IN_seg),
        .OUT_value(OUT_value),
        .OUT_off_number(OUT_off_number),
        .OUT_valid(OUT_valid),
        .OUT_err(OUT_err)
    );

    always #5 IN_clk = ~IN_clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] c, input logic [7:0] s);
        IN_choice = c;
        IN_seg = s;
        @(posedge IN_clk);
        #1;
    endtask

    task automatic push_ok(input logic [15:0] v, input logic [2:0] off);
        mdl_value = v;
        mdl_off = off;
        sb.push_back('{is_err: 1'b0, value: v, off: off});
    endtask

    task automatic push_err();
        sb.push_back('{is_err: 1'b1, value: mdl_value, off: mdl_off});
    endtask

    // Event monitor: every valid/err pulse must match the next queued event.
    always @(negedge IN_clk) begin
        if (!IN_rst && (OUT_valid || OUT_err)) begin
            chk("valid_err_exclusive", OUT_valid & OUT_err, 1'b0);
            chk("event_expected", sb.size() != 0, 1'b1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                chk("event_kind_err", OUT_err, mon_e.is_err);
                chk("event_value", OUT_value, mon_e.value);
                chk("event_off", {13'd0, OUT_off_number}, {13'd0, mon_e.off});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(posedge IN_clk);
        #1;
        chk("rst_value", OUT_value, 16'h0000);
        chk("rst_off", {13'd0, OUT_off_number}, 16'd0);
        chk("rst_valid", OUT_valid, 1'b0);
        chk("rst_err", OUT_err, 1'b0);
        IN_rst = 1'b0;

        // Plain frame, then an identical back-to-back frame.
        drive(4'b0001, 8'h71);
        drive(4'b0010, 8'h0D);
        drive(4'b0100, 8'h11);
        chk("t1_no_early_valid", OUT_valid, 1'b0);
        push_ok(16'h1A3F, 3'd0);
        drive(4'b1000, 8'h9F);
        chk("t1_valid_4th_edge", OUT_valid, 1'b1);
        chk("t1_value", OUT_value, 16'h1A3F);
        drive(4'b0001, 8'h71);
        chk("t1_valid_drops", OUT_valid, 1'b0);
        drive(4'b0010, 8'h0D);
        drive(4'b0100, 8'h11);
        push_ok(16'h1A3F, 3'd0);
        drive(4'b1000, 8'h9F);
        chk("t1b_valid_4th_edge", OUT_valid, 1'b1);

        // Held digits with garbage on hold cycles, two leading blanks.
        drive(4'b0001, 8'hC1); drive(4'b0001, 8'h00); drive(4'b0001, 8'h00);
        drive(4'b0010, 8'h11); drive(4'b0010, 8'h00); drive(4'b0010, 8'h00);
        drive(4'b0100, 8'hFF); drive(4'b0100, 8'h00); drive(4'b0100, 8'h00);
        push_ok(16'h00AB, 3'd2);
        drive(4'b1000, 8'hFF);
        chk("t2_valid", OUT_valid, 1'b1);
        drive(4'b1000, 8'h00); drive(4'b1000, 8'h00);

        // Not one-hot select.
        drive(4'b0001, 8'h03);
        push_err();
        drive(4'b0011, 8'h03);
        chk("t3a_err", OUT_err, 1'b1);
        chk("t3a_value_kept", OUT_value, 16'h00AB);
        // Out-of-sequence select.
        drive(4'b0001, 8'h03);
        push_err();
        drive(4'b0100, 8'h25);
        chk("t3b_err", OUT_err, 1'b1);
        // Full frame, then an illegal code for the next digit0.
        drive(4'b0001, 8'h03);
        drive(4'b0010, 8'h9F);
        drive(4'b0100, 8'h25);
        push_ok(16'h3210, 3'd0);
        drive(4'b1000, 8'h0D);
        push_err();
        drive(4'b0001, 8'hFE);
        chk("t3c_err", OUT_err, 1'b1);
        chk("t3c_value_kept", OUT_value, 16'h3210);

        // Non-contiguous blanks, then an all-blank frame.
        drive(4'b0001, 8'h03);
        drive(4'b0010, 8'hFF);
        drive(4'b0100, 8'h25);
        push_err();
        drive(4'b1000, 8'h9F);
        chk("t4_err", OUT_err, 1'b1);
        chk("t4_no_valid", OUT_valid, 1'b0);
        drive(4'b0001, 8'hFF);
        drive(4'b0010, 8'hFF);
        drive(4'b0100, 8'hFF);
        push_ok(16'h0000, 3'd4);
        drive(4'b1000, 8'hFF);
        chk("t4_off_all_blank", {13'd0, OUT_off_number}, 16'd4);

        // Hold timeout at MAX_HOLD=4, then a clean frame.
        drive(4'b0001, 8'h03);
        drive(4'b0001, 8'h03);
        drive(4'b0001, 8'h03);
        drive(4'b0001, 8'h03);
        chk("t5_no_early_timeout", OUT_err, 1'b0);
        push_err();
        drive(4'b0001, 8'h03);
        chk("t5_timeout_err", OUT_err, 1'b1);
        drive(4'b0001, 8'h99);
        drive(4'b0010, 8'h49);
        drive(4'b0100, 8'h41);
        push_ok(16'h7654, 3'd0);
        drive(4'b1000, 8'h1F);
        chk("t5_value", OUT_value, 16'h7654);

        // Asynchronous reset mid-frame discards the partial frame.
        drive(4'b0001, 8'h03);
        drive(4'b0010, 8'h0D);
        drive(4'b0100, 8'h25);
        IN_rst = 1'b1;
        #1;
        chk("t6_rst_value", OUT_value, 16'h0000);
        chk("t6_rst_off", {13'd0, OUT_off_number}, 16'd0);
        mdl_value = 16'h0000;
        mdl_off = 3'd0;
        #2;
        IN_rst = 1'b0;
        drive(4'b0100, 8'h25);
        drive(4'b1000, 8'h9F);
        chk("t6_hunt_no_valid", OUT_valid, 1'b0);
        chk("t6_hunt_no_err", OUT_err, 1'b0);
        drive(4'b0001, 8'h09);
        drive(4'b0010, 8'h01);
        drive(4'b0100, 8'h1F);
        push_ok(16'h6789, 3'd0);
        drive(4'b1000, 8'h41);
        chk("t6_value", OUT_value, 16'h6789);
        drive(4'b1000, 8'h41);
        drive(4'b1000, 8'h41);

        chk("sb_drained", sb.size() == 0, 1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
